// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin sharing of one external iterative Sqrt unit; SQRT_ARB_TIMEOUT_EN adds a WAIT watchdog
module sqrt_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TOTAL_WIDTH = 16,
  parameter int FRACTION_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*TOTAL_WIDTH-1:0] req_rad,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [TOTAL_WIDTH-1:0]         resp_root,
  output logic [TOTAL_WIDTH-1:0]         resp_rem,
  output logic                           resp_err,
  output logic                           sq_start,
  output logic [TOTAL_WIDTH-1:0]         sq_rad,
  input  logic                           sq_busy,
  input  logic                           sq_valid,
  input  logic [TOTAL_WIDTH-1:0]         sq_root,
  input  logic [TOTAL_WIDTH-1:0]         sq_rem
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [PW-1:0] last_grant, id_q, winner;
  logic [TOTAL_WIDTH-1:0] rad_q, root_q, rem_q, rad_sel;
  logic found, take, tmo, fin, err_q;
  if (NUM_REQ < 2 || NUM_REQ > 8 || FRACTION_WIDTH > TOTAL_WIDTH || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sqrt_arbiter: illegal parameter combination");
  end
  // Round-robin search starting just after the last grant; smallest offset wins.
  always_comb begin
    winner = '0;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[PW'((int'(last_grant) + k) % NUM_REQ)]) begin
        winner = PW'((int'(last_grant) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end
  // Select the winning requester's radicand.
  always_comb begin
    rad_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) rad_sel = (winner == PW'(i)) ? req_rad[i*TOTAL_WIDTH +: TOTAL_WIDTH] : rad_sel;
  end
`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // Watchdog counts WAIT cycles; every other state holds it at zero, so each ISSUE starts fresh.
  always_ff @(posedge clk) cnt <= (rst || state != WAIT) ? '0 : cnt + 1'b1;
  assign tmo = state == WAIT && !sq_valid && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  // Next state and handshake outputs; a stray sq_valid outside WAIT has no effect.
  always_comb begin
    take = state == IDLE && !sq_busy && found;
    fin = state == WAIT && (sq_valid || tmo);
    state_n = (state == IDLE) ? (take ? ISSUE : IDLE) :
              (state == ISSUE) ? WAIT :
              (state == WAIT) ? (fin ? DONE : WAIT) : IDLE;
    req_ready = take ? NUM_REQ'(1) << winner : '0;
    resp_valid = (state == DONE) ? NUM_REQ'(1) << id_q : '0;
    sq_start = state == ISSUE;
  end
  // State, grant pointer, latched job and captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= PW'(NUM_REQ - 1);
      id_q <= '0;
      rad_q <= '0;
      root_q <= '0;
      rem_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (take) begin
        rad_q <= rad_sel;
        id_q <= winner;
        last_grant <= winner;
      end
      if (fin) begin
        root_q <= sq_valid ? sq_root : '0;
        rem_q <= sq_valid ? sq_rem : '0;
        err_q <= !sq_valid;
      end
    end
  end
  assign sq_rad = rad_q;
  assign resp_root = root_q;
  assign resp_rem = rem_q;
  assign resp_err = err_q;
endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: directed vector bench for sqrt_arbiter with a behavioural Sqrt unit
module tb_sqrt_arbiter;
  localparam int N = 4, W = 16, F = 8, TO = 64, LAT = 12;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, resp_valid;
  logic [N*W-1:0] req_rad = '0;
  logic [W-1:0] resp_root, resp_rem, sq_rad;
  logic resp_err, sq_start, sq_busy;
  logic sq_valid = 1'b0;
  logic [W-1:0] sq_root = '0, sq_rem = '0;
  logic [4:0] m_cnt = '0;
  logic [W-1:0] m_rad = '0;
  logic [31:0] m_v;
  logic hold_busy = 1'b0, mute = 1'b0;
  int checks = 0, fails = 0;
  typedef struct {
    bit do_rst;
    logic [N-1:0] set;
    logic [N*W-1:0] rads;
    int id;
    logic [W-1:0] root;
    logic [W-1:0] rem;
  } vec_t;
  vec_t vecs[7];
  always #5 clk = ~clk;
  sqrt_arbiter #(.NUM_REQ(N), .TOTAL_WIDTH(W), .FRACTION_WIDTH(F), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rad(req_rad), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_root(resp_root), .resp_rem(resp_rem), .resp_err(resp_err),
    .sq_start(sq_start), .sq_rad(sq_rad), .sq_busy(sq_busy), .sq_valid(sq_valid),
    .sq_root(sq_root), .sq_rem(sq_rem)
  );
  function automatic logic [31:0] isqrt(input logic [31:0] v);
    logic [31:0] r = '0;
    for (int b = 15; b >= 0; b--)
      if (((r | (32'd1 << b)) * (r | (32'd1 << b))) <= v) r = r | (32'd1 << b);
    return r;
  endfunction
  assign m_v = {8'h00, m_rad, 8'h00};
  assign sq_busy = (m_cnt != 0) || hold_busy;
  // Behavioural Sqrt: fixed latency, not reset by rst, can be muted to never answer.
  always @(posedge clk) begin
    sq_valid <= 1'b0;
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1'b1;
      if (m_cnt == 1 && !mute) begin
        sq_valid <= 1'b1;
        sq_root <= W'(isqrt(m_v));
        sq_rem <= W'(m_v - isqrt(m_v) * isqrt(m_v));
      end
    end else if (sq_start) begin
      m_cnt <= 5'(LAT);
      m_rad <= sq_rad;
    end
  end
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1; req_valid = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reset outputs", {req_ready, resp_valid, resp_root, resp_rem, resp_err, sq_start, sq_rad}, 64'd0);
  endtask
  task automatic serve(input int id, input logic [W-1:0] rad, input logic [W-1:0] root, input logic [W-1:0] rem);
    int n = 0;
    while (req_ready == 0 && n < 300) begin
      if (resp_valid != 0) check("stray resp_valid", resp_valid, 64'd0);
      @(negedge clk); n++;
    end
    check("grant", req_ready, N'(1) << id);
    @(posedge clk); #1 req_valid[id] = 1'b0;
    @(negedge clk); check("sq_start/sq_rad", {sq_start, sq_rad}, {1'b1, rad});
    @(negedge clk); check("sq_start pulse", sq_start, 64'd0);
    n = 0;
    while (resp_valid == 0 && n < 300) begin @(negedge clk); n++; end
    check("response", {resp_valid, resp_root, resp_rem, resp_err}, {N'(1) << id, root, rem, 1'b0});
    @(negedge clk); check("resp_valid pulse", resp_valid, 64'd0);
  endtask
  initial begin #200000; $display("FAIL watchdog: simulation did not finish"); $fatal; end
  initial begin
    int n, bad;
    vecs[0] = '{1'b1, 4'b0001, 64'h0000_0000_0000_E890, 0, 16'h0F40, 16'h0000};
    vecs[1] = '{1'b1, 4'b1111, 64'h1000_0400_0200_0040, 0, 16'h0080, 16'h0000};
    vecs[2] = '{1'b0, 4'b0000, 64'h0, 1, 16'h016A, 16'h001C};
    vecs[3] = '{1'b0, 4'b0000, 64'h0, 2, 16'h0200, 16'h0000};
    vecs[4] = '{1'b0, 4'b0000, 64'h0, 3, 16'h0400, 16'h0000};
    vecs[5] = '{1'b0, 4'b0101, 64'h0000_0900_0000_0100, 0, 16'h0100, 16'h0000};
    vecs[6] = '{1'b0, 4'b0000, 64'h0, 2, 16'h0300, 16'h0000};
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_rst) do_reset();
      if (vecs[i].set != 0) begin
        @(posedge clk); #1;
        for (int j = 0; j < N; j++)
          if (vecs[i].set[j]) begin
            req_valid[j] = 1'b1;
            req_rad[j*W +: W] = vecs[i].rads[j*W +: W];
          end
        @(negedge clk);
      end
      serve(vecs[i].id, req_rad[vecs[i].id*W +: W], vecs[i].root, vecs[i].rem);
    end
    do_reset();
    @(posedge clk); #1 hold_busy = 1'b1; req_valid[1] = 1'b1; req_rad[W +: W] = 16'h0400;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready != 0 || sq_start) bad++;
    end
    check("busy gating", bad, 64'd0);
    @(posedge clk); #1 hold_busy = 1'b0;
    @(negedge clk); check("grant on busy drop", req_ready, 64'h2);
    serve(1, 16'h0400, 16'h0200, 16'h0000);
    @(posedge clk); #1 req_valid[2] = 1'b1; req_rad[2*W +: W] = 16'h0900;
    @(negedge clk);
    n = 0;
    while (req_ready == 0 && n < 50) begin @(negedge clk); n++; end
    check("pre-reset grant", req_ready, 64'h4);
    @(posedge clk); #1 req_valid[2] = 1'b0;
    repeat (4) @(negedge clk);
    do_reset();
    @(posedge clk); #1 req_valid = 4'b1001; req_rad[0 +: W] = 16'h0040; req_rad[3*W +: W] = 16'h1000;
    @(negedge clk);
    serve(0, 16'h0040, 16'h0080, 16'h0000);
    serve(3, 16'h1000, 16'h0400, 16'h0000);
`ifdef SQRT_ARB_TIMEOUT_EN
    mute = 1'b1;
    @(posedge clk); #1 req_valid[1] = 1'b1; req_rad[W +: W] = 16'h0400;
    @(negedge clk);
    n = 0;
    while (req_ready == 0 && n < 100) begin @(negedge clk); n++; end
    check("timeout grant", req_ready, 64'h2);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk);
    n = 1;
    while (resp_valid == 0 && n < 300) begin @(negedge clk); n++; end
    check("timeout latency", n, TO + 2);
    check("timeout response", {resp_valid, resp_root, resp_rem, resp_err}, {4'b0010, 16'h0, 16'h0, 1'b1});
    mute = 1'b0;
    @(posedge clk); #1 req_valid[0] = 1'b1; req_rad[0 +: W] = 16'h0100;
    @(negedge clk);
    serve(0, 16'h0100, 16'h0100, 16'h0000);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
